// File: rtl/csr_commit_ctrl.sv
// Writeback commit controller: turns each retiring instruction into a CSR write,
// an exception flush or an ertn flush, then holds off commits through a drain window.
module csr_commit_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CSR_ADDR_W   = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ws_valid,
    input  logic [31:0]           ws_pc,
    input  logic [4:0]            ws_ex,
    input  logic                  ws_ertn,
    input  logic                  ws_csr_we,
    input  logic [CSR_ADDR_W-1:0] ws_csr_num,
    input  logic [31:0]           ws_csr_wdata,
    input  logic                  has_int,
    input  logic [31:0]           csr_eentry,
    input  logic [31:0]           csr_era,
    output logic                  ws_allowin,
    output logic                  csr_wr_en,
    output logic [CSR_ADDR_W-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  excp_flush,
    output logic                  ertn_flush,
    output logic [31:0]           era_in,
    output logic [5:0]            ecode_in,
    output logic [8:0]            esubcode_in,
    output logic                  flush_valid,
    output logic [31:0]           flush_pc
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            state_p1;
    logic [CNT_W-1:0]      drain_cnt_p1;
    logic                  int_pending_p1;
    logic                  csr_wr_en_p1;
    logic [CSR_ADDR_W-1:0] wr_addr_p1;
    logic [31:0]           wr_data_p1;
    logic                  excp_flush_p1;
    logic                  ertn_flush_p1;
    logic [31:0]           era_in_p1;
    logic [5:0]            ecode_in_p1;
    logic                  flush_valid_p1;
    logic [31:0]           flush_pc_p1;

    logic                  commit_p0;
    logic                  excp_hit_p0;
    logic [5:0]            ecode_p0;

    // Stage p0: classify the retiring instruction
    always_comb begin
        commit_p0   = ws_valid && (state_p1 == S_IDLE);
        excp_hit_p0 = int_pending_p1 || (|ws_ex);
        if (int_pending_p1)  ecode_p0 = 6'h00;
        else if (ws_ex[0])   ecode_p0 = 6'h08;
        else if (ws_ex[1])   ecode_p0 = 6'h0D;
        else if (ws_ex[2])   ecode_p0 = 6'h0B;
        else if (ws_ex[3])   ecode_p0 = 6'h0C;
        else                 ecode_p0 = 6'h09;
    end

    // Stage p1: registered commands and flush sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1       <= S_IDLE;
            drain_cnt_p1   <= '0;
            int_pending_p1 <= 1'b0;
            csr_wr_en_p1   <= 1'b0;
            wr_addr_p1     <= '0;
            wr_data_p1     <= '0;
            excp_flush_p1  <= 1'b0;
            ertn_flush_p1  <= 1'b0;
            era_in_p1      <= '0;
            ecode_in_p1    <= '0;
            flush_valid_p1 <= 1'b0;
            flush_pc_p1    <= '0;
        end else begin
            int_pending_p1 <= has_int;
            csr_wr_en_p1   <= 1'b0;
            excp_flush_p1  <= 1'b0;
            ertn_flush_p1  <= 1'b0;
            flush_valid_p1 <= 1'b0;

            case (state_p1)
                S_FLUSH: begin
                    state_p1     <= S_DRAIN;
                    drain_cnt_p1 <= CNT_W'(DRAIN_CYCLES - 1);
                end
                S_DRAIN: begin
                    if (drain_cnt_p1 == '0) state_p1 <= S_IDLE;
                    else                    drain_cnt_p1 <= drain_cnt_p1 - CNT_W'(1);
                end
                default: begin
                    if (commit_p0) begin
                        // An excepting instruction never executes, so its ertn/CSR write is dropped
                        if (excp_hit_p0) begin
                            excp_flush_p1  <= 1'b1;
                            era_in_p1      <= ws_pc;
                            ecode_in_p1    <= ecode_p0;
                            flush_valid_p1 <= 1'b1;
                            flush_pc_p1    <= csr_eentry;
                            state_p1       <= S_FLUSH;
                        end else if (ws_ertn) begin
                            ertn_flush_p1  <= 1'b1;
                            flush_valid_p1 <= 1'b1;
                            flush_pc_p1    <= csr_era;
                            state_p1       <= S_FLUSH;
                        end else if (ws_csr_we) begin
                            csr_wr_en_p1   <= 1'b1;
                            wr_addr_p1     <= ws_csr_num;
                            wr_data_p1     <= ws_csr_wdata;
                        end
                    end
                end
            endcase
        end
    end

    assign ws_allowin  = (state_p1 == S_IDLE);
    assign csr_wr_en   = csr_wr_en_p1;
    assign wr_addr     = wr_addr_p1;
    assign wr_data     = wr_data_p1;
    assign excp_flush  = excp_flush_p1;
    assign ertn_flush  = ertn_flush_p1;
    assign era_in      = era_in_p1;
    assign ecode_in    = ecode_in_p1;
    assign esubcode_in = 9'd0;
    assign flush_valid = flush_valid_p1;
    assign flush_pc    = flush_pc_p1;

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Scoreboard bench for csr_commit_ctrl: expected outputs are queued as stimulus is
// driven and compared one cycle later when the registered commands appear.
module tb_csr_commit_ctrl;

    localparam int DRAIN_CYCLES = 2;
    localparam int CSR_ADDR_W   = 14;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  ws_valid;
    logic [31:0]           ws_pc;
    logic [4:0]            ws_ex;
    logic                  ws_ertn;
    logic                  ws_csr_we;
    logic [CSR_ADDR_W-1:0] ws_csr_num;
    logic [31:0]           ws_csr_wdata;
    logic                  has_int;
    logic [31:0]           csr_eentry;
    logic [31:0]           csr_era;
    logic                  ws_allowin;
    logic                  csr_wr_en;
    logic [CSR_ADDR_W-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic                  excp_flush;
    logic                  ertn_flush;
    logic [31:0]           era_in;
    logic [5:0]            ecode_in;
    logic [8:0]            esubcode_in;
    logic                  flush_valid;
    logic [31:0]           flush_pc;

    csr_commit_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CSR_ADDR_W(CSR_ADDR_W)) dut (
        .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_ex(ws_ex),
        .ws_ertn(ws_ertn), .ws_csr_we(ws_csr_we), .ws_csr_num(ws_csr_num),
        .ws_csr_wdata(ws_csr_wdata), .has_int(has_int), .csr_eentry(csr_eentry),
        .csr_era(csr_era), .ws_allowin(ws_allowin), .csr_wr_en(csr_wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .excp_flush(excp_flush),
        .ertn_flush(ertn_flush), .era_in(era_in), .ecode_in(ecode_in),
        .esubcode_in(esubcode_in), .flush_valid(flush_valid), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    // strobe vector: {excp_flush, ertn_flush, csr_wr_en, flush_valid, ws_allowin}
    typedef struct {
        logic [4:0]            strb;
        logic [CSR_ADDR_W-1:0] addr;
        logic [31:0]           data;
        logic [31:0]           era;
        logic [5:0]            ecode;
        logic [31:0]           fpc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    logic [4:0] strb;
    assign strb = {excp_flush, ertn_flush, csr_wr_en, flush_valid, ws_allowin};

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] ex,
                         input logic er, input logic we, input logic [CSR_ADDR_W-1:0] num,
                         input logic [31:0] wd);
        ws_valid = v; ws_pc = pc; ws_ex = ex; ws_ertn = er;
        ws_csr_we = we; ws_csr_num = num; ws_csr_wdata = wd;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 5'b0, 1'b0, 1'b0, '0, 32'h0);
    endtask

    task automatic push(input logic [4:0] s, input logic [CSR_ADDR_W-1:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic [5:0] ec, input logic [31:0] fp);
        exp_t x;
        x.strb = s; x.addr = a; x.data = d; x.era = er; x.ecode = ec; x.fpc = fp;
        sb.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e = sb.pop_front();
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); has_int = 1'b0; csr_eentry = 32'h0; csr_era = 32'h0;
        push(5'b00001, '0, 32'h0, 32'h0, 6'h0, 32'h0);
        step(); push(5'b00001, '0, 32'h0, 32'h0, 6'h0, 32'h0); step();
        checks++; if (strb !== e.strb) begin errors++; $display("FAIL reset_strb got %b exp %b", strb, e.strb); end
        checks++; if ({era_in, flush_pc, wr_data} !== {e.era, e.fpc, e.data})
            begin errors++; $display("FAIL reset_data got %h %h %h exp 0", era_in, flush_pc, wr_data); end
        checks++; if ({ecode_in, esubcode_in, wr_addr} !== {e.ecode, 9'd0, e.addr})
            begin errors++; $display("FAIL reset_codes got %h %h %h exp 0", ecode_in, esubcode_in, wr_addr); end
        reset = 1'b0;
    endtask

    task automatic test_csrw();
        drive(1'b1, 32'h1C000000, 5'b0, 1'b0, 1'b1, 14'h30, 32'hDEADBEEF);
        push(5'b00101, 14'h30, 32'hDEADBEEF, 32'h0, 6'h0, 32'h0);
        step(); idle();
        checks++; if (strb !== e.strb) begin errors++; $display("FAIL csrw_strb got %b exp %b", strb, e.strb); end
        checks++; if (wr_addr !== e.addr) begin errors++; $display("FAIL csrw_addr got %h exp %h", wr_addr, e.addr); end
        checks++; if (wr_data !== e.data) begin errors++; $display("FAIL csrw_data got %h exp %h", wr_data, e.data); end
        push(5'b00001, 14'h30, 32'hDEADBEEF, 32'h0, 6'h0, 32'h0);
        step();
        checks++; if (strb !== e.strb) begin errors++; $display("FAIL csrw_pulse_end got %b exp %b", strb, e.strb); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h1C000010, 5'b0, 1'b0, 1'b1, 14'(16'h100 + i), 32'hA5A50000 + 32'(i));
            push(5'b00101, 14'(16'h100 + i), 32'hA5A50000 + 32'(i), 32'h0, 6'h0, 32'h0);
            step();
            checks++; if ({strb, wr_addr, wr_data} !== {e.strb, e.addr, e.data})
                begin errors++; $display("FAIL b2b_%0d got %b %h %h exp %b %h %h", i, strb, wr_addr, wr_data, e.strb, e.addr, e.data); end
        end
        idle();
    endtask

    task automatic test_sys_drain();
        csr_eentry = 32'h1C008000;
        drive(1'b1, 32'h1C000100, 5'b00100, 1'b0, 1'b0, '0, 32'h0);
        push(5'b10010, '0, 32'h0, 32'h1C000100, 6'h0B, 32'h1C008000);
        step();
        checks++; if (strb !== e.strb) begin errors++; $display("FAIL sys_strb got %b exp %b", strb, e.strb); end
        checks++; if ({era_in, ecode_in, flush_pc} !== {e.era, e.ecode, e.fpc})
            begin errors++; $display("FAIL sys_data got %h %h %h exp %h %h %h", era_in, ecode_in, flush_pc, e.era, e.ecode, e.fpc); end
        // wrong-path CSR writes offered during the flush/drain window must be dropped
        drive(1'b1, 32'h1C000104, 5'b0, 1'b0, 1'b1, 14'h31, 32'h12345678);
        for (int i = 0; i < DRAIN_CYCLES; i++) begin
            push(5'b00000, '0, 32'h0, 32'h1C000100, 6'h0B, 32'h1C008000);
            step();
            checks++; if (strb !== e.strb) begin errors++; $display("FAIL sys_drain_%0d got %b exp %b", i, strb, e.strb); end
        end
        push(5'b00001, '0, 32'h0, 32'h1C000100, 6'h0B, 32'h1C008000);
        step(); idle();
        checks++; if (strb !== e.strb) begin errors++; $display("FAIL sys_reopen got %b exp %b", strb, e.strb); end
        checks++; if ({era_in, ecode_in} !== {e.era, e.ecode})
            begin errors++; $display("FAIL sys_hold got %h %h exp %h %h", era_in, ecode_in, e.era, e.ecode); end
    endtask

    task automatic test_priority();
        csr_eentry = 32'h1C009000;
        drive(1'b1, 32'h1C000300, 5'b10011, 1'b1, 1'b1, 14'h32, 32'h0BADF00D);
        push(5'b10010, '0, 32'h0, 32'h1C000300, 6'h08, 32'h1C009000);
        step(); idle();
        checks++; if (strb !== e.strb) begin errors++; $display("FAIL prio_strb got %b exp %b", strb, e.strb); end
        checks++; if ({ecode_in, flush_pc} !== {e.ecode, e.fpc})
            begin errors++; $display("FAIL prio_data got %h %h exp %h %h", ecode_in, flush_pc, e.ecode, e.fpc); end
        for (int i = 0; i <= DRAIN_CYCLES; i++) begin
            push((i == DRAIN_CYCLES) ? 5'b00001 : 5'b00000, '0, 32'h0, 32'h0, 6'h0, 32'h0);
            step();
            checks++; if (strb !== e.strb) begin errors++; $display("FAIL prio_drain_%0d got %b exp %b", i, strb, e.strb); end
        end
    endtask

    task automatic test_interrupt();
        csr_eentry = 32'h1C008000;
        has_int = 1'b1;
        push(5'b00001, '0, 32'h0, 32'h0, 6'h0, 32'h0);
        step();
        checks++; if (strb !== e.strb) begin errors++; $display("FAIL int_arm got %b exp %b", strb, e.strb); end
        has_int = 1'b0;
        drive(1'b1, 32'h1C000200, 5'b0, 1'b0, 1'b1, 14'h40, 32'hCAFEF00D);
        push(5'b10010, '0, 32'h0, 32'h1C000200, 6'h00, 32'h1C008000);
        step(); idle();
        checks++; if (strb !== e.strb) begin errors++; $display("FAIL int_strb got %b exp %b", strb, e.strb); end
        checks++; if ({era_in, ecode_in, flush_pc} !== {e.era, e.ecode, e.fpc})
            begin errors++; $display("FAIL int_data got %h %h %h exp %h %h %h", era_in, ecode_in, flush_pc, e.era, e.ecode, e.fpc); end
        for (int i = 0; i <= DRAIN_CYCLES; i++) begin
            push((i == DRAIN_CYCLES) ? 5'b00001 : 5'b00000, '0, 32'h0, 32'h0, 6'h0, 32'h0);
            step();
            checks++; if (strb !== e.strb) begin errors++; $display("FAIL int_drain_%0d got %b exp %b", i, strb, e.strb); end
        end
    endtask

    task automatic test_ertn();
        csr_era = 32'h1C000204;
        drive(1'b1, 32'h1C000400, 5'b0, 1'b1, 1'b0, '0, 32'h0);
        push(5'b01010, '0, 32'h0, 32'h1C000200, 6'h00, 32'h1C000204);
        step(); idle();
        checks++; if (strb !== e.strb) begin errors++; $display("FAIL ertn_strb got %b exp %b", strb, e.strb); end
        checks++; if ({flush_pc, era_in} !== {e.fpc, e.era})
            begin errors++; $display("FAIL ertn_data got %h %h exp %h %h", flush_pc, era_in, e.fpc, e.era); end
        for (int i = 0; i <= DRAIN_CYCLES; i++) begin
            push((i == DRAIN_CYCLES) ? 5'b00001 : 5'b00000, '0, 32'h0, 32'h0, 6'h0, 32'h0);
            step();
            checks++; if (strb !== e.strb) begin errors++; $display("FAIL ertn_drain_%0d got %b exp %b", i, strb, e.strb); end
        end
    endtask

    task automatic test_reset_in_drain();
        drive(1'b1, 32'h1C000500, 5'b01000, 1'b0, 1'b0, '0, 32'h0);
        push(5'b10010, '0, 32'h0, 32'h1C000500, 6'h0C, 32'h1C008000);
        step(); idle();
        checks++; if ({strb, ecode_in} !== {e.strb, e.ecode})
            begin errors++; $display("FAIL brk_strb got %b %h exp %b %h", strb, ecode_in, e.strb, e.ecode); end
        push(5'b00000, '0, 32'h0, 32'h0, 6'h0, 32'h0);
        step();
        checks++; if (strb !== e.strb) begin errors++; $display("FAIL rst_pre got %b exp %b", strb, e.strb); end
        reset = 1'b1;
        push(5'b00001, '0, 32'h0, 32'h0, 6'h0, 32'h0);
        step(); reset = 1'b0;
        checks++; if (strb !== e.strb) begin errors++; $display("FAIL rst_drain got %b exp %b", strb, e.strb); end
        push(5'b00001, '0, 32'h0, 32'h0, 6'h0, 32'h0);
        step();
        checks++; if (strb !== e.strb) begin errors++; $display("FAIL rst_noreissue got %b exp %b", strb, e.strb); end
        drive(1'b1, 32'h1C000600, 5'b0, 1'b0, 1'b1, 14'h55, 32'h12345678);
        push(5'b00101, 14'h55, 32'h12345678, 32'h0, 6'h0, 32'h0);
        step(); idle();
        checks++; if ({strb, wr_addr, wr_data} !== {e.strb, e.addr, e.data})
            begin errors++; $display("FAIL rst_csrw got %b %h %h exp %b %h %h", strb, wr_addr, wr_data, e.strb, e.addr, e.data); end
    endtask

    initial begin
        test_reset();
        test_csrw();
        test_back_to_back();
        test_sys_drain();
        test_priority();
        test_interrupt();
        test_ertn();
        test_reset_in_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
